// File: rtl/pixel_serializer_pkg.sv
// Shared constants and types for the pixel output stage.
// Colour and row widths stay module parameters; only width-independent items live here.
package pixel_serializer_pkg;

  localparam logic HSCALE_1X = 1'b0;
  localparam logic HSCALE_2X = 1'b1;

  typedef struct packed {
    logic blink;
    logic cursor;
    logic hscale;
  } cell_flags_t;

  function automatic int cnt_width(input int char_width);
    return $clog2(char_width + 1);
  endfunction

endpackage

// File: rtl/pixel_colour_select.sv
// Combinational colour pick for one pixel: cursor fg/bg swap, blink masking, blanking.
// Kept separate so later overlay planes can share the same rules.
module pixel_colour_select #(
  parameter int COLOR_BITS = 3
) (
  input  logic                  pixel_bit,
  input  logic [COLOR_BITS-1:0] foreground,
  input  logic [COLOR_BITS-1:0] background,
  input  logic                  blink,
  input  logic                  cursor,
  input  logic                  blinking,
  input  logic                  drawing,
  output logic [COLOR_BITS-1:0] colour
);

  logic [COLOR_BITS-1:0] fore_eff;
  logic [COLOR_BITS-1:0] back_eff;
  logic                  visible;

  always_comb begin
    fore_eff = foreground;
    back_eff = background;
    // cursor cell inverts only during the visible blink phase
    if (cursor && blinking) begin
      fore_eff = background;
      back_eff = foreground;
    end
    visible = pixel_bit & (~blink | blinking);
    colour  = '0;
    if (drawing) begin
      colour = visible ? fore_eff : back_eff;
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// Character-row pixel serializer: captures a glyph row and attributes on load,
// then shifts one pixel per clock (optionally doubled) onto the colour DAC.
//
// state   | meaning
// ST_IDLE | no pending pixels; dac shows background while drawing (underrun)
// ST_EMIT | pixels of the latched cell still pending
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int COLOR_BITS = 3,
  parameter int CHAR_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [CHAR_WIDTH-1:0] row,
  input  logic [COLOR_BITS-1:0] foreground,
  input  logic [COLOR_BITS-1:0] background,
  input  logic                  blink,
  input  logic                  cursor,
  input  logic                  hscale,
  input  logic                  blinking,
  input  logic                  drawing,
  output logic [COLOR_BITS-1:0] dac,
  output logic                  busy,
  output logic                  underrun
);

  localparam int CNT_W = cnt_width(CHAR_WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]            state;
  logic [CHAR_WIDTH-1:0] shift_reg;
  logic [CHAR_WIDTH-1:0] row_ordered;
  logic [CNT_W-1:0]      pix_cnt;
  logic                  rep_cnt;
  logic [COLOR_BITS-1:0] fg_q;
  logic [COLOR_BITS-1:0] bg_q;
  cell_flags_t           flags_q;
  logic [COLOR_BITS-1:0] emit_colour;

  // the emitted bit is always the shift MSB, so LSB-first rows are reversed at load
  always_comb begin
    row_ordered = row;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < CHAR_WIDTH; i++) begin
        row_ordered[i] = row[CHAR_WIDTH-1-i];
      end
    end
  end

  pixel_colour_select #(
    .COLOR_BITS(COLOR_BITS)
  ) u_colour_select (
    .pixel_bit (shift_reg[CHAR_WIDTH-1]),
    .foreground(fg_q),
    .background(bg_q),
    .blink     (flags_q.blink),
    .cursor    (flags_q.cursor),
    .blinking  (blinking),
    .drawing   (drawing),
    .colour    (emit_colour)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dac       <= '0;
      underrun  <= 1'b0;
      shift_reg <= '0;
      pix_cnt   <= '0;
      rep_cnt   <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
      flags_q   <= '0;
    end else if (load) begin
      // old cell's current MSB and attributes still drive dac on the load edge
      dac            <= emit_colour;
      shift_reg      <= row_ordered;
      fg_q           <= foreground;
      bg_q           <= background;
      flags_q.blink  <= blink;
      flags_q.cursor <= cursor;
      flags_q.hscale <= hscale;
      pix_cnt        <= CNT_W'(CHAR_WIDTH);
      rep_cnt        <= (hscale == HSCALE_2X);
      state          <= ST_EMIT;
    end else begin
      case (state)
        ST_EMIT: begin
          dac <= emit_colour;
          if (rep_cnt == 1'b0) begin
            shift_reg <= shift_reg << 1;
            pix_cnt   <= pix_cnt - CNT_W'(1);
            rep_cnt   <= (flags_q.hscale == HSCALE_2X);
            if (pix_cnt == CNT_W'(1)) begin
              state <= ST_IDLE;
            end
          end else begin
            rep_cnt <= 1'b0;
          end
        end
        default: begin
          dac <= drawing ? bg_q : '0;
          if (drawing) begin
            underrun <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_EMIT);

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: MSB-first and LSB-first instances against a
// queue-based pixel model, with directed literal checks followed by random traffic.
`timescale 1ns/1ps
module tb_pixel_serializer;

  localparam int CB = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [CW-1:0] row = '0;
  logic [CB-1:0] foreground = '0;
  logic [CB-1:0] background = '0;
  logic          blink = 1'b0;
  logic          cursor = 1'b0;
  logic          hscale = 1'b0;
  logic          blinking = 1'b0;
  logic          drawing = 1'b0;

  logic [CB-1:0] dac_m, dac_l;
  logic          busy_m, busy_l, under_m, under_l;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pixel_serializer #(.COLOR_BITS(CB), .CHAR_WIDTH(CW), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .load(load), .row(row), .foreground(foreground),
    .background(background), .blink(blink), .cursor(cursor), .hscale(hscale),
    .blinking(blinking), .drawing(drawing), .dac(dac_m), .busy(busy_m), .underrun(under_m)
  );

  pixel_serializer #(.COLOR_BITS(CB), .CHAR_WIDTH(CW), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .load(load), .row(row), .foreground(foreground),
    .background(background), .blink(blink), .cursor(cursor), .hscale(hscale),
    .blinking(blinking), .drawing(drawing), .dac(dac_l), .busy(busy_l), .underrun(under_l)
  );

  // ---------------- behavioural model ----------------
  bit            q_m[$];
  bit            q_l[$];
  logic [CB-1:0] a_fg = '0, a_bg = '0;
  logic          a_bl = 1'b0, a_cur = 1'b0;
  logic [CB-1:0] m_dac_m = '0, m_dac_l = '0;
  logic          m_busy = 1'b0, m_under = 1'b0;

  function automatic logic [CB-1:0] pick(input bit b);
    logic [CB-1:0] f, g;
    f = a_fg;
    g = a_bg;
    if (a_cur && blinking) begin
      f = a_bg;
      g = a_fg;
    end
    if (!drawing) return '0;
    return (b && (!a_bl || blinking)) ? f : g;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q_m.delete();
      q_l.delete();
      a_fg = '0; a_bg = '0; a_bl = 1'b0; a_cur = 1'b0;
      m_dac_m = '0; m_dac_l = '0; m_busy = 1'b0; m_under = 1'b0;
    end else if (load) begin
      m_dac_m = pick((q_m.size() > 0) ? q_m[0] : 1'b0);
      m_dac_l = pick((q_l.size() > 0) ? q_l[0] : 1'b0);
      q_m.delete();
      q_l.delete();
      for (int p = 0; p < CW; p++) begin
        for (int r = 0; r < (hscale ? 2 : 1); r++) begin
          q_m.push_back(row[CW-1-p]);
          q_l.push_back(row[p]);
        end
      end
      a_fg = foreground; a_bg = background; a_bl = blink; a_cur = cursor;
      m_busy = 1'b1;
    end else if (q_m.size() > 0) begin
      m_dac_m = pick(q_m.pop_front());
      m_dac_l = pick(q_l.pop_front());
      m_busy = (q_m.size() > 0);
    end else begin
      m_dac_m = drawing ? a_bg : '0;
      m_dac_l = m_dac_m;
      if (drawing) m_under = 1'b1;
      m_busy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model dac msb", 32'(dac_m), 32'(m_dac_m));
      chk("model dac lsb", 32'(dac_l), 32'(m_dac_l));
      chk("model busy msb", 32'(busy_m), 32'(m_busy));
      chk("model busy lsb", 32'(busy_l), 32'(m_busy));
      chk("model underrun msb", 32'(under_m), 32'(m_under));
      chk("model underrun lsb", 32'(under_l), 32'(m_under));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [CW-1:0] r, input logic [CB-1:0] f, input logic [CB-1:0] b,
                         input logic bl, input logic cur, input logic hs);
    row = r; foreground = f; background = b; blink = bl; cursor = cur; hscale = hs;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  logic [CB-1:0] exp_norm[8];
  int gap;
  int len;

  initial begin
    exp_norm = '{3'd7, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7};

    tick();
    chk_en = 1'b1;
    chk("reset dac", 32'(dac_m), 0);
    chk("reset busy", 32'(busy_m), 0);
    chk("reset underrun", 32'(under_m), 0);
    reset = 1'b0;

    // reset mid-cell
    drawing = 1'b1;
    do_load(8'hA5, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0);
    tick(); chk("a5 pixel0", 32'(dac_m), 7);
    tick(); chk("a5 pixel1", 32'(dac_m), 5);
    reset = 1'b1;
    tick(); chk("midreset dac", 32'(dac_m), 0); chk("midreset busy", 32'(busy_m), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("post reset dac", 32'(dac_m), 0); chk("post reset busy", 32'(busy_m), 0);
    end

    // normal 1x with seamless reload
    do_reset();
    drawing = 1'b1; blinking = 1'b0;
    do_load(8'b1100_0001, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        row = 8'h00; load = 1'b1;
      end
      tick();
      load = 1'b0;
      chk("normal 1x pixel", 32'(dac_m), 32'(exp_norm[i]));
    end
    chk("normal reload busy", 32'(busy_m), 1);
    chk("normal no underrun", 32'(under_m), 0);

    // 2x replication
    do_reset();
    do_load(8'h80, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("2x pixel", 32'(dac_m), (i < 2) ? 2 : 0);
      if (i == 14) chk("2x busy held", 32'(busy_m), 1);
      if (i == 15) chk("2x busy fall", 32'(busy_m), 0);
    end

    // blink hidden, then cursor swap
    do_reset();
    blinking = 1'b0;
    do_load(8'hFF, 3'd6, 3'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(); chk("blink hidden", 32'(dac_m), 3);
    end
    blinking = 1'b1;
    do_load(8'hFF, 3'd6, 3'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(); chk("cursor swap", 32'(dac_m), 3);
    end

    // underrun
    do_reset();
    blinking = 1'b0; drawing = 1'b1;
    do_load(8'h00, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("underrun before", 32'(under_m), 0);
    tick();
    chk("underrun dac", 32'(dac_m), 6);
    chk("underrun flag", 32'(under_m), 1);

    // blanking mid-cell
    do_reset();
    do_load(8'hFF, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    drawing = 1'b0;
    tick();
    chk("blank dac", 32'(dac_m), 0);
    chk("blank underrun", 32'(under_m), 0);
    chk("blank busy", 32'(busy_m), 1);
    drawing = 1'b1;
    tick();
    chk("unblank dac", 32'(dac_m), 4);

    // early reload
    do_reset();
    do_load(8'h00, 3'd7, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    do_load(8'h80, 3'd4, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("early load edge dac", 32'(dac_m), 1);
    tick();
    chk("early new pixel0", 32'(dac_m), 4);
    chk("early no underrun", 32'(under_m), 0);

    // bit order
    do_reset();
    do_load(8'h01, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lsb first pixel0", 32'(dac_l), 5);
    chk("msb first pixel0", 32'(dac_m), 2);

    // randomized traffic
    do_reset();
    gap = 0;
    len = CW;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) drawing = ~drawing;
      if ($urandom_range(0, 49) == 0) blinking = ~blinking;
      load = 1'b0;
      if (gap <= 0) begin
        row = CW'($urandom);
        foreground = CB'($urandom);
        background = CB'($urandom);
        blink = ($urandom_range(0, 3) == 0);
        cursor = ($urandom_range(0, 5) == 0);
        hscale = ($urandom_range(0, 2) == 0);
        load = 1'b1;
        len = hscale ? 2 * CW : CW;
        if ($urandom_range(0, 9) < 6) gap = len;
        else gap = int'($urandom_range(1, 2 * CW + 6));
      end
      tick();
      gap--;
    end
    reset = 1'b0;
    load = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
